// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 2-flop line synchronizer,
// mid-bit alignment, 3-sample majority voting, parity/framing/break status,
// a single-entry output holding register and a sticky overrun flag.
//
// Output handshake (valid/ready): o_valid rises when a frame is loaded and
// holds, with o_data and the status flags stable, until a cycle where
// o_valid && i_ready; o_valid then drops on the next edge unless a new frame
// completes in that same cycle, in which case the new frame is loaded and
// o_valid stays high. A frame completing while o_valid && !i_ready is
// dropped and o_overrun is set until the next accepting handshake.
module uart_rx_cfg #(
  parameter int CLKS_PER_BAUD = 434,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int MSB_FIRST     = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_data_line,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_C     = CW'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] SAMP0_C    = CW'(CLKS_PER_BAUD - 3);
  localparam logic [CW-1:0] SAMP1_C    = CW'(CLKS_PER_BAUD - 2);
  localparam logic [CW-1:0] LAST_C     = CW'(CLKS_PER_BAUD - 1);
  localparam logic [3:0]    LAST_BIT_C = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shift_next;
  logic                   par_bit;
  logic                   zero_run;   // every bit so far in this frame was 0
  logic                   stop_idx;
  logic                   stop_bad;
  logic                   brk_r;
  logic                   samp0;
  logic                   samp1;
  logic                   maj;
  logic                   bit_end;
  logic                   last_stop;
  logic                   perr_calc;

  // Frame result handed from the receive FSM to the holding register
  logic                   done;
  logic [DATA_BITS-1:0]   f_data;
  logic                   f_perr;
  logic                   f_ferr;
  logic                   f_brk;

  assign maj         = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign bit_end     = (cnt == LAST_C);
  assign last_stop   = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  // Next shift-register value for the bit resolving this cycle
  always_comb begin
    shift_next = shreg;
    if (MSB_FIRST != 0) shift_next = {shreg[DATA_BITS-2:0], maj};
    else                shift_next = {maj, shreg[DATA_BITS-1:1]};
  end

  // Parity check of the assembled word against the received parity bit
  always_comb begin
    perr_calc = 1'b0;
    if (PARITY_MODE == 1)      perr_calc = ~(^shreg ^ par_bit);
    else if (PARITY_MODE == 2) perr_calc = ^shreg ^ par_bit;
  end

  // Two-flop synchronizer, reset to the idle (high) line level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx_data_line;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: start qualification, bit timing, voting and frame status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      zero_run <= 1'b1;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      brk_r    <= 1'b0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      done     <= 1'b0;
      f_data   <= '0;
      f_perr   <= 1'b0;
      f_ferr   <= 1'b0;
      f_brk    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DATA || state == PARITY || state == STOP) begin
        if (cnt == SAMP0_C) samp0 <= rx_s;
        if (cnt == SAMP1_C) samp1 <= rx_s;
        if (bit_end) cnt <= '0;
        else         cnt <= cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (rx_s) begin
            // Line returned high before mid-start: treat as noise
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == HALF_C) begin
            state    <= DATA;
            cnt      <= '0;
            bit_idx  <= '0;
            zero_run <= 1'b1;
            stop_idx <= 1'b0;
            stop_bad <= 1'b0;
            brk_r    <= 1'b0;
            par_bit  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg    <= shift_next;
            zero_run <= zero_run & ~maj;
            if (bit_idx == LAST_BIT_C) begin
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_bit  <= maj;
            zero_run <= zero_run & ~maj;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              done   <= 1'b1;
              f_data <= shreg;
              f_perr <= perr_calc;
              f_ferr <= stop_bad | ~maj;
              f_brk  <= stop_idx ? brk_r : (zero_run & ~maj);
              // A low final stop bit means the line may still be held low
              state  <= maj ? IDLE : BRK_WAIT;
            end else begin
              stop_idx <= 1'b1;
              stop_bad <= ~maj;
              brk_r    <= zero_run & ~maj;
            end
          end
        end
        BRK_WAIT: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output holding register, handshake and sticky overrun
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (done && (!o_valid || i_ready)) begin
        o_valid      <= 1'b1;
        o_data       <= f_data;
        o_parity_err <= f_perr;
        o_frame_err  <= f_ferr;
        o_break      <= f_brk;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (done && o_valid && !i_ready) o_overrun <= 1'b1;
      else if (o_valid && i_ready)     o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receivers at 16 clocks per bit (8N1, 8E1, 8N2)
// driven by bit-level tasks; received frames are compared against
// hand-computed expectations from a vector table and directed sequences.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk;
  logic rst_n;
  logic rx_a, rx_b, rx_c;
  logic rdy_a, rdy_b, rdy_c;

  logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
  logic [7:0] a_data;
  logic [2:0] a_state;
  logic       b_valid, b_perr, b_ferr, b_brk, b_ovr, b_busy;
  logic [7:0] b_data;
  logic [2:0] b_state;
  logic       c_valid, c_perr, c_ferr, c_brk, c_ovr, c_busy;
  logic [7:0] c_data;
  logic [2:0] c_state;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount_a = 0;

  // Frame word: {data, parity_err, frame_err, break}
  logic [10:0] exp_q[$];
  logic [10:0] act_q[$];

  typedef struct {
    int         ln;
    logic [7:0] data;
    logic       par;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  vec_t vecs[14];

  uart_rx_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                .STOP_BITS(1), .MSB_FIRST(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx_a), .i_ready(rdy_a),
    .o_valid(a_valid), .o_data(a_data), .o_parity_err(a_perr),
    .o_frame_err(a_ferr), .o_break(a_brk), .o_overrun(a_ovr),
    .o_busy(a_busy), .o_dbg_state(a_state)
  );

  uart_rx_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                .STOP_BITS(1), .MSB_FIRST(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx_b), .i_ready(rdy_b),
    .o_valid(b_valid), .o_data(b_data), .o_parity_err(b_perr),
    .o_frame_err(b_ferr), .o_break(b_brk), .o_overrun(b_ovr),
    .o_busy(b_busy), .o_dbg_state(b_state)
  );

  uart_rx_cfg #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                .STOP_BITS(2), .MSB_FIRST(0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data_line(rx_c), .i_ready(rdy_c),
    .o_valid(c_valid), .o_data(c_data), .o_parity_err(c_perr),
    .o_frame_err(c_ferr), .o_break(c_brk), .o_overrun(c_ovr),
    .o_busy(c_busy), .o_dbg_state(c_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: record every accepted frame and count o_valid cycles of dut_a
  always @(negedge clk) begin
    if (a_valid && rdy_a) act_q.push_back({a_data, a_perr, a_ferr, a_brk});
    if (b_valid && rdy_b) act_q.push_back({b_data, b_perr, b_ferr, b_brk});
    if (c_valid && rdy_c) act_q.push_back({c_data, c_perr, c_ferr, c_brk});
    if (a_valid) vcount_a <= vcount_a + 1;
  end

  function automatic logic [10:0] fw(input logic [7:0] d, input logic p,
                                     input logic f, input logic b);
    return {d, p, f, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int ln, input logic v);
    case (ln)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // One bit period; glitch_off >= 0 inverts the line for that single cycle
  task automatic send_bit(input int ln, input logic b, input int glitch_off);
    for (int i = 0; i < CPB; i++) begin
      set_line(ln, (i == glitch_off) ? ~b : b);
      tick();
    end
  endtask

  // Start, 8 data bits LSB first, parity on line 1, two stops on line 2.
  // The line is left at the last stop value.
  task automatic send_frame(input int ln, input logic [7:0] d, input logic par,
                            input logic s0, input logic s1, input int glitch_bit);
    send_bit(ln, 1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(ln, d[i], (i == glitch_bit) ? 6 : -1);
    if (ln == 1) send_bit(ln, par, -1);
    send_bit(ln, s0, -1);
    if (ln == 2) send_bit(ln, s1, -1);
  endtask

  // Scoreboard: wait (bounded) for one accepted frame and compare it
  task automatic wait_result(input string name);
    int t;
    logic [10:0] act;
    logic [10:0] exp;
    t = 0;
    while (act_q.size() == 0 && t < 200) begin
      tick();
      t++;
    end
    if (act_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=no frame within 200 cycles required=frame", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      act = act_q.pop_front();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=%0h required=no frame", name, act);
      end else begin
        exp = exp_q.pop_front();
        check(name, 32'(act), 32'(exp));
      end
    end
  endtask

  initial begin
    int v0;

    vecs[0]  = '{0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{2, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{2, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

    // Reset
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
    hold(4);
    check("reset outputs a", 32'({a_valid, a_data, a_perr, a_ferr, a_brk, a_ovr, a_busy}), 32'd0);
    check("reset outputs b", 32'({b_valid, b_data, b_perr, b_ferr, b_brk, b_ovr, b_busy}), 32'd0);
    check("reset outputs c", 32'({c_valid, c_data, c_perr, c_ferr, c_brk, c_ovr, c_busy}), 32'd0);
    check("reset state", 32'({a_state, b_state, c_state}), 32'd0);
    rst_n = 1'b1;
    hold(8);

    // Table-driven frames
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(fw(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk));
      send_frame(vecs[i].ln, vecs[i].data, vecs[i].par, vecs[i].s0, vecs[i].s1, -1);
      wait_result($sformatf("vec%0d", i));
      set_line(vecs[i].ln, 1'b1);
      hold(2 * CPB);
    end

    // 8N1 0x55: o_valid is a single-cycle pulse with i_ready high
    v0 = vcount_a;
    exp_q.push_back(fw(8'h55, 1'b0, 1'b0, 1'b0));
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, -1);
    wait_result("8n1 0x55");
    hold(4);
    check("8n1 valid pulse width", 32'(vcount_a - v0), 32'd1);
    hold(2 * CPB);

    // Short low pulse is rejected as a false start
    v0 = vcount_a;
    set_line(0, 1'b0);
    hold(5);
    set_line(0, 1'b1);
    hold(4 * CPB);
    check("glitch no valid", 32'(vcount_a - v0), 32'd0);
    check("glitch state idle", 32'(a_state), 32'd0);

    // One-cycle glitches at mid data bit are outvoted
    exp_q.push_back(fw(8'h55, 1'b0, 1'b0, 1'b0));
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 0);
    wait_result("vote glitch on 1");
    set_line(0, 1'b1);
    hold(2 * CPB);
    exp_q.push_back(fw(8'hC6, 1'b0, 1'b0, 1'b0));
    send_frame(0, 8'hC6, 1'b0, 1'b1, 1'b1, 3);
    wait_result("vote glitch on 0");
    set_line(0, 1'b1);
    hold(2 * CPB);

    // Overrun: two frames with no consumer, then accept
    rdy_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, -1);
    set_line(0, 1'b1);
    hold(2 * CPB);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1);
    set_line(0, 1'b1);
    hold(2 * CPB);
    check("ovr valid held", 32'(a_valid), 32'd1);
    check("ovr data kept", 32'(a_data), 32'h11);
    check("ovr flag set", 32'(a_ovr), 32'd1);
    check("ovr no handshake", 32'(act_q.size()), 32'd0);
    exp_q.push_back(fw(8'h11, 1'b0, 1'b0, 1'b0));
    rdy_a = 1'b1;
    wait_result("ovr handshake");
    tick();
    check("ovr cleared", 32'({a_valid, a_ovr}), 32'd0);
    hold(CPB);

    // 8N2: low second stop, line held low, then recovery
    exp_q.push_back(fw(8'h0F, 1'b0, 1'b1, 1'b0));
    send_frame(2, 8'h0F, 1'b0, 1'b1, 1'b0, -1);
    wait_result("8n2 bad 2nd stop");
    hold(3 * CPB);
    check("brk_wait held", 32'(c_state), 32'd5);
    check("brk_wait no frame", 32'({c_valid, 24'(act_q.size())}), 32'd0);
    set_line(2, 1'b1);
    hold(2 * CPB);
    check("brk_wait released", 32'(c_state), 32'd0);
    exp_q.push_back(fw(8'h12, 1'b0, 1'b0, 1'b0));
    send_frame(2, 8'h12, 1'b0, 1'b1, 1'b1, -1);
    wait_result("8n2 after break");
    set_line(2, 1'b1);
    hold(2 * CPB);

    // Reset during data bit 4 clears a held frame and aborts the current one
    rdy_a = 1'b0;
    send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, -1);
    set_line(0, 1'b1);
    hold(CPB);
    check("held before reset", 32'({a_valid, a_data}), 32'h133);
    send_bit(0, 1'b0, -1);
    send_bit(0, 1'b0, -1);
    send_bit(0, 1'b1, -1);
    send_bit(0, 1'b1, -1);
    send_bit(0, 1'b1, -1);
    set_line(0, 1'b1);
    hold(8);
    rst_n = 1'b0;
    hold(2);
    check("mid-frame reset outputs", 32'({a_valid, a_data, a_perr, a_ferr, a_brk, a_ovr, a_busy}), 32'd0);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    hold(4 * CPB);
    check("no frame after reset", 32'({a_valid, 24'(act_q.size())}), 32'd0);
    exp_q.push_back(fw(8'h7E, 1'b0, 1'b0, 1'b0));
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1, -1);
    wait_result("after reset 0x7E");
    set_line(0, 1'b1);
    hold(2 * CPB);

    check("leftover expectations", 32'(exp_q.size()), 32'd0);
    check("leftover frames", 32'(act_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
